// File: rtl/sync_time_div_scheduler_if.sv
// Link between the resync scheduler and the shared pipelined 64/16 modulo divider.
// Handshake: DIV_VALID qualifies DIVIDEND/DIVISOR for one cycle. There is no ready: the divider
// accepts an operand every cycle and returns DIV_REM a fixed DIV_LATENCY edges later, unqualified.
interface sync_time_div_scheduler_if;
    logic [63:0] DIV_DIVIDEND;
    logic [15:0] DIV_DIVISOR;
    logic        DIV_VALID;
    logic [15:0] DIV_REM;

    modport master (output DIV_DIVIDEND, output DIV_DIVISOR, output DIV_VALID, input DIV_REM);
    modport slave  (input DIV_DIVIDEND, input DIV_DIVISOR, input DIV_VALID, output DIV_REM);
endinterface

// File: rtl/sync_time_div_scheduler.sv
// Per-channel modulo time counters, resynchronised to SYS_TIME by sweeping every channel
// through one shared pipelined divider and loading the returned remainders.
module sync_time_div_scheduler #(
    parameter int N_CH        = 249,
    parameter int DIV_LATENCY = 68
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [63:0]               SYS_TIME,
    input  logic [N_CH*13-1:0]        CYCLE,
    input  logic                      SYNC_REQ,
    sync_time_div_scheduler_if.master div,
    output logic [N_CH*13-1:0]        TIME_CNT,
    output logic                      BUSY,
    output logic                      SWEEP_DONE,
    output logic [1:0]                DBG_STATE
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          last;
        logic          vld;
        logic [IW-1:0] idx;
    } tag_t;

    state_t        state;
    logic          pending;
    logic [IW-1:0] idx;
    logic [12:0]   cyc_sel;
    tag_t          tag_in;
    tag_t          tag_p [DIV_LATENCY+1];
    tag_t          tag_out;

    assign cyc_sel   = CYCLE[int'(idx)*13 +: 13];
    assign tag_out   = tag_p[DIV_LATENCY];
    assign BUSY      = (state != IDLE);
    assign DBG_STATE = state;

    // Periods below 2 still take their issue slot but never load.
    always_comb begin
        tag_in = '0;
        if (state == ISSUE) begin
            tag_in.last = (idx == LAST_IDX);
            tag_in.vld  = (cyc_sel >= 13'd2);
            tag_in.idx  = idx;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= IDLE;
            pending          <= 1'b0;
            idx              <= '0;
            SWEEP_DONE       <= 1'b0;
            div.DIV_VALID    <= 1'b0;
            div.DIV_DIVIDEND <= '0;
            div.DIV_DIVISOR  <= '0;
        end else begin
            SWEEP_DONE    <= 1'b0;
            div.DIV_VALID <= 1'b0;
            if (SYNC_REQ && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (SYNC_REQ || pending) begin
                        state   <= ISSUE;
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Dividend is the system time at the moment the remainder becomes visible.
                    div.DIV_VALID    <= 1'b1;
                    div.DIV_DIVISOR  <= {3'b000, cyc_sel};
                    div.DIV_DIVIDEND <= SYS_TIME + 64'(DIV_LATENCY + 2);
                    if (idx == LAST_IDX) state <= DRAIN;
                    else                 idx   <= idx + 1'b1;
                end
                DRAIN: begin
                    if (tag_out.last) begin
                        state      <= IDLE;
                        SWEEP_DONE <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tags ride alongside the divider so each exits in the cycle its remainder is valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i <= DIV_LATENCY; i++) tag_p[i] <= '0;
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i <= DIV_LATENCY; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [12:0] cyc_k;
        logic [12:0] cnt;
        logic        load;

        assign cyc_k = CYCLE[k*13 +: 13];
        // A remainder of a 13-bit divisor always fits 13 bits; anything else is not ours.
        assign load  = tag_out.vld && (tag_out.idx == IW'(k)) && (div.DIV_REM[15:13] == 3'b000);

        always_ff @(posedge CLK or posedge RST) begin
            if (RST)                                      cnt <= '0;
            else if (load)                                cnt <= div.DIV_REM[12:0];
            else if (cyc_k < 13'd2 || cnt >= cyc_k - 13'd1) cnt <= '0;
            else                                          cnt <= cnt + 13'd1;
        end

        assign TIME_CNT[k*13 +: 13] = cnt;
    end
endmodule

// File: tb/tb_sync_time_div_scheduler.sv
// Directed bench for sync_time_div_scheduler with a behavioural pipelined modulo divider.
module tb_sync_time_div_scheduler;
  localparam int N_CH      = 4;
  localparam int L         = 5;
  localparam int SWEEP_LEN = N_CH + L + 1;
  localparam int CW        = N_CH * 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   sys_time;
  logic [CW-1:0] cycle;
  logic          sync_req;
  logic [CW-1:0] time_cnt;
  logic          busy;
  logic          sweep_done;
  logic [1:0]    dbg_state;

  sync_time_div_scheduler_if div_bus ();

  sync_time_div_scheduler #(.N_CH(N_CH), .DIV_LATENCY(L)) u_dut (
    .CLK        (clk),
    .RST        (rst),
    .SYS_TIME   (sys_time),
    .CYCLE      (cycle),
    .SYNC_REQ   (sync_req),
    .div        (div_bus),
    .TIME_CNT   (time_cnt),
    .BUSY       (busy),
    .SWEEP_DONE (sweep_done),
    .DBG_STATE  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural divider: sampled on an edge, remainder valid L-1 edges later, never reset
  logic [15:0] rem_p [L];
  initial for (int i = 0; i < L; i++) rem_p[i] = 16'h0;
  always @(posedge clk) begin
    if (div_bus.DIV_VALID && div_bus.DIV_DIVISOR != 16'd0)
      rem_p[0] <= 16'(div_bus.DIV_DIVIDEND % 64'(div_bus.DIV_DIVISOR));
    else
      rem_p[0] <= 16'h0ABC;
    for (int i = 1; i < L; i++) rem_p[i] <= rem_p[i-1];
  end
  assign div_bus.DIV_REM = rem_p[L-1];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // scoreboard
  int          n_vec = 0;
  int          n_bad = 0;
  logic [12:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {13'(d), 13'(c), 13'(b), 13'(a)};
  endfunction

  function automatic logic [CW-1:0] model_cnt(input logic [63:0] t, input logic [CW-1:0] cyc);
    logic [CW-1:0] r;
    logic [12:0]   c;
    r = '0;
    for (int k = 0; k < N_CH; k++) begin
      c = cyc[k*13 +: 13];
      r[k*13 +: 13] = (c < 13'd2) ? 13'd0 : 13'(t % 64'(c));
    end
    return r;
  endfunction

  // driver tasks: SYS_TIME advances by one just after every edge
  task automatic tick();
    @(posedge clk);
    #1;
    sys_time = sys_time + 64'd1;
  endtask

  task automatic pulse_sync();
    sync_req = 1'b1;
    tick();
    sync_req = 1'b0;
  endtask

  task automatic run_sweep(input string name);
    int n;
    bit seen;
    pulse_sync();
    check({name, " busy_on_entry"}, busy, 1);
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      tick();
      n++;
      if (sweep_done) seen = 1;
      for (int k = 0; k < N_CH; k++)
        if (cycle[k*13 +: 13] == 13'd0) check({name, " zero_period_held"}, time_cnt[k*13 +: 13], 0);
    end
    check({name, " sweep_latency"}, n, SWEEP_LEN);
    check({name, " busy_at_done"}, busy, 0);
  endtask

  task automatic free_run(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check(name, time_cnt, model_cnt(sys_time, cycle));
    end
  endtask

  typedef struct {
    string         name;
    logic [CW-1:0] cyc;
    logic [63:0]   s;
    logic [CW-1:0] exp;
    int            nfree;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int pulses;
    vecs[0] = '{name: "v_base",  cyc: pack4(4096, 4000, 100, 2), s: 64'd123445,
                exp: pack4(576, 3456, 56, 0), nfree: 10000};
    vecs[1] = '{name: "v_zero",  cyc: pack4(4096, 4000, 0, 2),   s: 64'd999990,
                exp: pack4(577, 1, 0, 1), nfree: 50};
    vecs[2] = '{name: "v_wrap",  cyc: pack4(8191, 13, 7, 3),     s: 64'hFFFF_FFFF_FFFF_FFFA,
                exp: pack4(5, 5, 5, 2), nfree: 50};

    rst      = 1'b1;
    sync_req = 1'b0;
    sys_time = 64'd0;
    cycle    = vecs[0].cyc;
    tick();
    tick();
    check("reset time_cnt", time_cnt, 0);
    check("reset div_valid", div_bus.DIV_VALID, 0);
    check("reset div_dividend", div_bus.DIV_DIVIDEND, 0);
    check("reset div_divisor", div_bus.DIV_DIVISOR, 0);
    check("reset busy", busy, 0);
    check("reset sweep_done", sweep_done, 0);
    check("reset state", dbg_state, 0);
    rst = 1'b0;
    tick();
    tick();

    // table: SYS_TIME at the SWEEP_DONE cycle is s + 11, expected counts hand-computed
    for (int v = 0; v < 3; v++) begin
      cycle    = vecs[v].cyc;
      sys_time = vecs[v].s;
      run_sweep(vecs[v].name);
      for (int k = 0; k < N_CH; k++) exp_q.push_back(vecs[v].exp[k*13 +: 13]);
      for (int k = 0; k < N_CH; k++) check({vecs[v].name, " loaded"}, time_cnt[k*13 +: 13], exp_q.pop_front());
      free_run({vecs[v].name, " freerun"}, vecs[v].nfree);
    end

    // SYS_TIME jump: counters keep the old phase until the next sweep
    cycle = vecs[0].cyc;
    run_sweep("jump_presync");
    check("jump_presync exact", time_cnt, model_cnt(sys_time, cycle));
    tick();
    sys_time = sys_time + 64'd777;
    check("jump old_phase", time_cnt, model_cnt(sys_time - 64'd777, cycle));
    tick();
    check("jump ch0 stale", time_cnt[12:0], 13'((sys_time - 64'd777) % 64'd4096));
    run_sweep("jump_sync");
    check("jump resynced", time_cnt, model_cnt(sys_time, cycle));
    free_run("jump freerun", 20);

    // period shrink below the current count
    begin
      int guard = 0;
      while (13'(sys_time % 64'd4096) != 13'd3000 && guard < 5000) begin
        tick();
        guard++;
      end
      check("shrink reach_3000", time_cnt[12:0], 3000);
      cycle[12:0] = 13'd50;
      tick();
      check("shrink wrap_to_0", time_cnt[12:0], 0);
      tick();
      check("shrink count_1", time_cnt[12:0], 1);
      run_sweep("shrink_sync");
      check("shrink resynced", time_cnt, model_cnt(sys_time, cycle));
      free_run("shrink freerun", 20);
    end

    // three requests during one sweep merge into a single extra sweep
    cycle = vecs[0].cyc;
    pulses = 0;
    pulse_sync();
    for (int i = 0; i < 40; i++) begin
      sync_req = (i == 1 || i == 3 || i == 5);
      tick();
      if (sweep_done) pulses++;
    end
    sync_req = 1'b0;
    check("merge sweep_done_pulses", pulses, 2);
    check("merge busy_idle", busy, 0);
    check("merge exact", time_cnt, model_cnt(sys_time, cycle));

    // reset in the middle of an issue phase
    pulse_sync();
    tick();
    tick();
    tick();
    check("midreset valid_before", div_bus.DIV_VALID, 1);
    rst = 1'b1;
    #1;
    check("midreset time_cnt", time_cnt, 0);
    check("midreset div_valid", div_bus.DIV_VALID, 0);
    check("midreset div_dividend", div_bus.DIV_DIVIDEND, 0);
    check("midreset div_divisor", div_bus.DIV_DIVISOR, 0);
    check("midreset busy", busy, 0);
    check("midreset sweep_done", sweep_done, 0);
    tick();
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("midreset stale_ignored", time_cnt, model_cnt(64'(n), cycle));
      check("midreset stays_idle", busy, 0);
    end
    run_sweep("midreset_sync");
    check("midreset resynced", time_cnt, model_cnt(sys_time, cycle));
    free_run("midreset freerun", 20);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
